// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encoding shared by the logic unit pipeline and its core
package logic_unit_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;
endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for the logic unit pipeline
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_eq;
  logic             out_par;
  logic             out_zero;
  logic [CNT_W-1:0] match_cnt;
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_eq, out_par, out_zero, match_cnt
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_eq, out_par, out_zero, match_cnt
  );
endinterface

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise op plus equality, parity and zero flags
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             eq,
  output logic             par,
  output logic             zero
);
  // per-bit op select; no carries between bits
  always_comb begin
    y = op == OP_AND  ? a & b    :
        op == OP_OR   ? a | b    :
        op == OP_XOR  ? a ^ b    :
        op == OP_XNOR ? a ~^ b   :
        op == OP_NAND ? ~(a & b) :
        op == OP_NOR  ? ~(a | b) :
        op == OP_ANDN ? a & ~b   : a;
  end
  // eq looks at the operands regardless of op; par/zero look at the result
  assign eq   = &(a ~^ b);
  assign par  = ^y;
  assign zero = ~|y;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with saturating match counter
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_eq;
  logic             s2_par;
  logic             s2_zero;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] core_y;
  logic             core_eq;
  logic             core_par;
  logic             core_zero;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             deliver;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = s2_valid && bus.out_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .op   (s1_op),
    .y    (core_y),
    .eq   (core_eq),
    .par  (core_par),
    .zero (core_zero)
  );

  // stage 1: capture operands on acceptance, empty when handed to stage 2 with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else begin
      s1_valid <= accept || (s1_valid && !s1_adv);
      if (accept) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_op <= op_e'(bus.in_op);
      end
    end
  end

  // stage 2: register result and flags; held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_eq    <= 1'b0;
      s2_par   <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y    <= core_y;
        s2_eq   <= core_eq;
        s2_par  <= core_par;
        s2_zero <= core_zero;
      end
    end
  end

  // count delivered equal-operand results, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (deliver && s2_eq && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_eq    = s2_eq;
  assign bus.out_par   = s2_par;
  assign bus.out_zero  = s2_zero;
  assign bus.match_cnt = cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed checks of the logic unit pipeline across three configurations
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) ia ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2)) ib ();
  logic_unit_pipe_if #(.WIDTH(1), .CNT_W(8)) ic ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  logic_unit_pipe #(.WIDTH(1), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] ys [8];

  initial begin
    ys = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h30, 8'hF0};
    ia.in_valid = 0; ia.in_a = 0; ia.in_b = 0; ia.in_op = 0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_a = 0; ib.in_b = 0; ib.in_op = 0; ib.out_ready = 1;
    ic.in_valid = 0; ic.in_a = 0; ic.in_b = 0; ic.in_op = 0; ic.out_ready = 1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_y", ia.out_y, 0);
    chk("rst_cnt", ia.match_cnt, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", ia.in_ready, 1);

    // single XNOR of equal operands
    ia.in_valid = 1; ia.in_a = 8'hA5; ia.in_b = 8'hA5; ia.in_op = 3'd3;
    @(negedge clk);
    ia.in_valid = 0;
    chk("xnor_lat1", ia.out_valid, 0);
    @(negedge clk);
    chk("xnor_valid", ia.out_valid, 1);
    chk("xnor_y", ia.out_y, 8'hFF);
    chk("xnor_eq", ia.out_eq, 1);
    chk("xnor_par", ia.out_par, 0);
    chk("xnor_zero", ia.out_zero, 0);
    chk("xnor_cnt0", ia.match_cnt, 0);
    @(negedge clk);
    chk("xnor_drain", ia.out_valid, 0);
    chk("xnor_cnt1", ia.match_cnt, 1);

    // all eight ops back to back
    ia.in_a = 8'hF0; ia.in_b = 8'hCC;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        chk($sformatf("op%0d_valid", k - 2), ia.out_valid, 1);
        chk($sformatf("op%0d_y", k - 2), ia.out_y, ys[k - 2]);
        chk($sformatf("op%0d_eq", k - 2), ia.out_eq, 0);
      end
      ia.in_valid = k < 8;
      ia.in_op = 3'(k);
      @(negedge clk);
    end
    chk("ops_drain", ia.out_valid, 0);
    chk("ops_cnt", ia.match_cnt, 1);

    // stall with downstream not ready
    ia.out_ready = 0;
    ia.in_valid = 1; ia.in_a = 8'h11; ia.in_b = 8'h22; ia.in_op = 3'd1;
    @(negedge clk);
    chk("stall_rdy1", ia.in_ready, 1);
    ia.in_a = 8'h44; ia.in_b = 8'h11;
    @(negedge clk);
    chk("stall_rdy2", ia.in_ready, 0);
    chk("stall_y0", ia.out_y, 8'h33);
    ia.in_a = 8'h0F; ia.in_b = 8'hF0;
    @(negedge clk);
    chk("stall_hold_v", ia.out_valid, 1);
    chk("stall_hold_y", ia.out_y, 8'h33);
    chk("stall_rdy3", ia.in_ready, 0);
    ia.out_ready = 1;
    #1;
    chk("stall_rdy_comb", ia.in_ready, 1);
    @(negedge clk);
    ia.in_valid = 0;
    chk("stall_y1", ia.out_y, 8'h55);
    @(negedge clk);
    chk("stall_y2", ia.out_y, 8'hFF);
    chk("stall_v2", ia.out_valid, 1);
    @(negedge clk);
    chk("stall_drain", ia.out_valid, 0);
    chk("stall_cnt", ia.match_cnt, 1);

    // saturating counter on the CNT_W=2 instance
    ib.in_a = 8'h3C; ib.in_b = 8'h3C; ib.in_op = 3'd2;
    for (int k = 0; k < 8; k++) begin
      if (k >= 2 && k <= 6) begin
        chk($sformatf("sat%0d_y", k - 2), ib.out_y, 0);
        chk($sformatf("sat%0d_zero", k - 2), ib.out_zero, 1);
        chk($sformatf("sat%0d_eq", k - 2), ib.out_eq, 1);
      end
      if (k >= 2) chk($sformatf("sat_cnt%0d", k), ib.match_cnt, (k - 2) > 3 ? 3 : k - 2);
      ib.in_valid = k < 5;
      @(negedge clk);
    end

    // WIDTH=1 instance
    ic.in_valid = 1; ic.in_a = 1; ic.in_b = 0; ic.in_op = 3'd3;
    @(negedge clk);
    ic.in_a = 1; ic.in_b = 1; ic.in_op = 3'd0;
    @(negedge clk);
    ic.in_valid = 0;
    chk("w1_y", ic.out_y, 0);
    chk("w1_eq", ic.out_eq, 0);
    chk("w1_par", ic.out_par, 0);
    chk("w1_zero", ic.out_zero, 1);
    @(negedge clk);
    chk("w1b_y", ic.out_y, 1);
    chk("w1b_eq", ic.out_eq, 1);
    chk("w1b_par", ic.out_par, 1);
    chk("w1b_zero", ic.out_zero, 0);

    // asynchronous reset with two results in flight
    ia.out_ready = 0;
    ia.in_valid = 1; ia.in_a = 8'h5A; ia.in_b = 8'h5A; ia.in_op = 3'd3;
    @(negedge clk);
    @(negedge clk);
    ia.in_valid = 0;
    chk("inflight_v", ia.out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", ia.out_valid, 0);
    chk("arst_cnt", ia.match_cnt, 0);
    chk("arst_cnt_b", ib.match_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    ia.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("arst_stale%0d", k), ia.out_valid, 0);
    end
    chk("arst_cnt_end", ia.match_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, two-stage pipelined bitwise logic unit; the successor to the single 1-bit XNOR primitive.
- Applies one of eight 2-input bitwise ops to WIDTH-bit operands and also produces equality (XNOR-reduce), parity and zero flags.
- Valid/ready handshake on both sides, so it slots between partial-product and comparison stages of the Vedic multiplier datapath.
- Keeps a saturating count of equal-operand results delivered downstream.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the match counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active low.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select.
- out_valid  output  1  result held on outputs.
- out_ready  input  1  downstream accepts.
- out_y  output  WIDTH  bitwise result.
- out_eq  output  1  1 when in_a == in_b (AND-reduce of a XNOR b).
- out_par  output  1  XOR-reduce of out_y.
- out_zero  output  1  1 when out_y == 0.
- match_cnt  output  CNT_W  results delivered with out_eq=1.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valid flags 0; out_y, out_eq, out_par, out_zero and match_cnt 0; in_ready 1 after reset release. Reset mid-transfer discards all in-flight data; nothing is replayed.
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 a&~b, 111 pass A. Every op is per bit; no carries.
- Stage 1 registers in_a, in_b and in_op on acceptance (in_valid && in_ready).
- Stage 2 computes y and the flags from stage-1 registers and registers them. Outputs come only from stage-2 registers.
- Latency: 2 cycles from acceptance to out_valid when not stalled.
- Throughput: 1 result per cycle while out_ready=1.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && that condition holds.
  - in_ready = !s1_valid || s1 advancing. This is a combinational path from out_ready, which is allowed.
- Hold rule: while out_valid && !out_ready, out_y and all flags stay stable.
- Simultaneous accept-in and deliver-out in a full pipeline: both transfers occur in the same cycle with no bubble.
- Bubbles: if s1 is empty, s2 drains and out_valid drops the cycle after delivery.
- out_eq is independent of in_op.
- out_par and out_zero are computed on y, not on the operands.
- match_cnt:
  - Increments by 1 on each output transfer (out_valid && out_ready) with out_eq=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- WIDTH=1 must degenerate cleanly: out_par = out_y, out_zero = ~out_y.

Decomposition:
- Shared package logic_unit_pkg holds the 3-bit op enum (OP_AND … OP_PASSA) and the op-width constant.
- One sub-module: logic_unit_core, purely combinational (a, b, op → y, eq, par, zero), parametrised on WIDTH. It is instantiated once in stage 2.
- The top level holds the pipeline registers, the handshake and the counter.

Test Plan:
- Reset then XNOR, a=8'hA5, b=8'hA5, out_ready=1 → 2 cycles later out_valid=1, y=8'hFF, eq=1, par=0, zero=0; match_cnt becomes 1 after transfer.
- Eight back-to-back ops with a=8'hF0, b=8'hCC, op=0..7 → y sequence C0, FC, 3C, C3, 3F, 03, 30, F0; one result per cycle; eq=0 throughout; match_cnt unchanged.
- Hold out_ready=0 after 2 accepts → in_ready=0 on the third cycle; outputs hold the first result. Release out_ready → results delivered in order, no loss, no duplication.
- CNT_W=2, five equal-operand XOR transfers (a=b=8'h3C, y=0, zero=1) → match_cnt goes 1, 2, 3, 3, 3.
- Assert rst_n low while two ops are in flight and out_ready=0 → out_valid=0 and match_cnt=0 immediately (asynchronously); no stale result appears after release.
- WIDTH=1 instance: a=1, b=0, op=XNOR → y=0, eq=0, par=0, zero=1.
